// File: rtl/adc_pingpong_capture_pkg.sv
// Shared types and helpers for the ping-pong ADC capture block.
// Holds the writer/bank state encodings, the mode constants and the RAM address packing.
package adc_capture_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, FILL, STALL} wr_state_e;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

    localparam logic MODE_FREERUN  = 1'b0;
    localparam logic MODE_LOSSLESS = 1'b1;

    // Packs {bank, channel, index} into a flat RAM address.
    function automatic int unsigned pack_addr(input int unsigned bank,
                                              input int unsigned ch,
                                              input int unsigned idx,
                                              input int unsigned ch_log2,
                                              input int unsigned depth_log2);
        return (bank << (ch_log2 + depth_log2)) | (ch << depth_log2) | idx;
    endfunction

endpackage

// File: rtl/adc_pingpong_capture_if.sv
// Bus bundle between the host/ADC side (master) and the capture block (slave).
// Signal names follow the established ADC_/BF_ prefixes of the original interface.
interface adc_pingpong_capture_if #(
    parameter int DATA_W     = 16,
    parameter int CH_LOG2    = 2,
    parameter int DEPTH_LOG2 = 11,
    parameter int DROP_W     = 16
);
    localparam int ADDR_W = 1 + CH_LOG2 + DEPTH_LOG2;

    logic              I_enable;
    logic              I_mode;
    logic              ADC_I_dataValid;
    logic [DATA_W-1:0] ADC_I_data;
    logic              ADC_I_sof;
    logic              BF_I_re;
    logic [ADDR_W-1:0] BF_I_addr;
    logic [DATA_W-1:0] BF_O_data;
    logic              BF_O_dataValid;
    logic              BF_I_release;
    logic              O_bankInUse;
    logic              O_bankReady;
    logic              O_readyBank;
    logic              O_overrun;
    logic [DROP_W-1:0] O_dropCount;
    logic              O_syncErr;
    logic              O_collision;

    modport master (
        output I_enable, I_mode, ADC_I_dataValid, ADC_I_data, ADC_I_sof,
               BF_I_re, BF_I_addr, BF_I_release,
        input  BF_O_data, BF_O_dataValid, O_bankInUse, O_bankReady, O_readyBank,
               O_overrun, O_dropCount, O_syncErr, O_collision
    );

    modport slave (
        input  I_enable, I_mode, ADC_I_dataValid, ADC_I_data, ADC_I_sof,
               BF_I_re, BF_I_addr, BF_I_release,
        output BF_O_data, BF_O_dataValid, O_bankInUse, O_bankReady, O_readyBank,
               O_overrun, O_dropCount, O_syncErr, O_collision
    );
endinterface

// File: rtl/capture_bank_ram.sv
// Simple dual-port RAM holding both capture banks: one write port, one registered read port.
module capture_bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)     rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/adc_pingpong_capture.sv
// Two-bank ping-pong capture of an interleaved multi-channel ADC stream with host read-out.
// Writer FSM, bank bookkeeping and sticky status live here; storage is capture_bank_ram.
module adc_pingpong_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CH_LOG2    = 2,
    parameter int DEPTH_LOG2 = 11,
    parameter int DROP_W     = 16
) (
    input logic                    I_clk,
    input logic                    I_rst,
    adc_pingpong_capture_if.slave  bus
);
    localparam int ADDR_W = 1 + CH_LOG2 + DEPTH_LOG2;

    wr_state_e              state;
    bank_state_e            bank_st [2];
    logic                   wr_bank;
    logic [CH_LOG2-1:0]     ch;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [DROP_W-1:0]      drop_cnt;
    logic                   overrun, sync_err, collision, rd_valid;

    logic                   any_full, both_full, ready_bank, rel_hit, other;
    logic                   wr_fire, last_write, other_free;
    logic [CH_LOG2-1:0]     wr_ch;
    logic [ADDR_W-1:0]      wr_addr;

    assign other      = ~wr_bank;
    assign any_full   = (bank_st[0] == FULL) || (bank_st[1] == FULL);
    assign both_full  = (bank_st[0] == FULL) && (bank_st[1] == FULL);
    // With both banks full the writer sits on its own bank, so the host owns the other one.
    assign ready_bank = both_full ? other : (bank_st[1] == FULL);
    assign rel_hit    = bus.BF_I_release && any_full;

    assign wr_fire    = bus.ADC_I_dataValid && bus.I_enable &&
                        ((state == FILL) || (state == WAIT_SOF && bus.ADC_I_sof));
    assign wr_ch      = bus.ADC_I_sof ? '0 : ch;
    assign last_write = (state == FILL) && wr_fire && (wr_ch == '1) && (idx == '1);
    // A release in the completing cycle frees the other bank before the swap decision.
    assign other_free = (bank_st[other] == EMPTY) || (rel_hit && (ready_bank == other));
    assign wr_addr    = ADDR_W'(pack_addr(32'(wr_bank), 32'(wr_ch), 32'(idx),
                                          CH_LOG2, DEPTH_LOG2));

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= IDLE;
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            ch         <= '0;
            idx        <= '0;
            drop_cnt   <= '0;
            overrun    <= 1'b0;
            sync_err   <= 1'b0;
            collision  <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= bus.BF_I_re;
            if (rel_hit) bank_st[ready_bank] <= EMPTY;
            if (bus.BF_I_re && (bus.BF_I_addr[ADDR_W-1] == wr_bank) && (state == FILL))
                collision <= 1'b1;

            if (!bus.I_enable) begin
                state <= IDLE;
                ch    <= '0;
                idx   <= '0;
                for (int b = 0; b < 2; b++)
                    if (bank_st[b] == FILLING) bank_st[b] <= EMPTY;
            end else begin
                case (state)
                    IDLE: state <= WAIT_SOF;
                    WAIT_SOF: if (wr_fire) begin
                        bank_st[wr_bank] <= FILLING;
                        ch    <= CH_LOG2'(1);
                        idx   <= '0;
                        state <= FILL;
                    end
                    FILL: if (wr_fire) begin
                        if (bus.ADC_I_sof && ch != '0) sync_err <= 1'b1;
                        if (last_write) begin
                            bank_st[wr_bank] <= FULL;
                            if (other_free || bus.I_mode == MODE_FREERUN) begin
                                if (!other_free) overrun <= 1'b1;
                                bank_st[other] <= FILLING;
                                wr_bank <= other;
                                ch      <= '0;
                                idx     <= '0;
                            end else begin
                                state <= STALL;
                            end
                        end else begin
                            ch <= wr_ch + CH_LOG2'(1);
                            if (wr_ch == '1) idx <= idx + DEPTH_LOG2'(1);
                        end
                    end
                    STALL: begin
                        if (bus.ADC_I_dataValid) begin
                            overrun <= 1'b1;
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
                        end
                        if (rel_hit) begin
                            wr_bank <= other;
                            ch      <= '0;
                            idx     <= '0;
                            state   <= WAIT_SOF;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    capture_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk     (I_clk),
        .rst     (I_rst),
        .we      (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (bus.ADC_I_data),
        .re      (bus.BF_I_re),
        .rd_addr (bus.BF_I_addr),
        .rd_data (bus.BF_O_data)
    );

    assign bus.BF_O_dataValid = rd_valid;
    assign bus.O_bankInUse    = wr_bank;
    assign bus.O_bankReady    = any_full;
    assign bus.O_readyBank    = any_full ? ready_bank : 1'b0;
    assign bus.O_overrun      = overrun;
    assign bus.O_dropCount    = drop_cnt;
    assign bus.O_syncErr      = sync_err;
    assign bus.O_collision    = collision;
endmodule

// File: tb/tb_adc_pingpong_capture.sv
// Directed bench for adc_pingpong_capture with 4 channels x 16 samples per bank.
module tb_adc_pingpong_capture;
    import adc_capture_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adc_pingpong_capture_if #(.DATA_W(16), .CH_LOG2(2), .DEPTH_LOG2(4), .DROP_W(16)) bus ();

    adc_pingpong_capture #(.DATA_W(16), .CH_LOG2(2), .DEPTH_LOG2(4), .DROP_W(16)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.I_enable = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic mode);
        bus.I_mode   = mode;
        bus.I_enable = 1'b1;
        tick();
    endtask

    // Sample presented for one clock; a release set by the caller rides the same cycle.
    task automatic sample(input int value, input logic sof);
        bus.ADC_I_dataValid = 1'b1;
        bus.ADC_I_data      = 16'(value);
        bus.ADC_I_sof       = sof;
        tick();
        bus.ADC_I_dataValid = 1'b0;
        bus.ADC_I_sof       = 1'b0;
        bus.BF_I_release    = 1'b0;
    endtask

    task automatic stream(input int first, input int count);
        for (int i = 0; i < count; i++) sample(first + i, (i % 4) == 0);
    endtask

    task automatic host_read(input int b, input int c, input int ix);
        bus.BF_I_re   = 1'b1;
        bus.BF_I_addr = 7'((b << 6) | (c << 4) | ix);
        tick();
        bus.BF_I_re   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.I_enable = 1'b0;
        bus.I_mode = 1'b0;
        bus.ADC_I_dataValid = 1'b0;
        bus.ADC_I_data = '0;
        bus.ADC_I_sof = 1'b0;
        bus.BF_I_re = 1'b0;
        bus.BF_I_addr = '0;
        bus.BF_I_release = 1'b0;
        tick();
        tick();

        check("rst_ready",     32'(bus.O_bankReady),    0);
        check("rst_readybank", 32'(bus.O_readyBank),    0);
        check("rst_inuse",     32'(bus.O_bankInUse),    0);
        check("rst_overrun",   32'(bus.O_overrun),      0);
        check("rst_drop",      32'(bus.O_dropCount),    0);
        check("rst_syncerr",   32'(bus.O_syncErr),      0);
        check("rst_collision", 32'(bus.O_collision),    0);
        check("rst_rdvalid",   32'(bus.BF_O_dataValid), 0);
        check("rst_rddata",    32'(bus.BF_O_data),      0);
        check("rst_state",     32'(dut.state),          32'(IDLE));
        rst = 1'b0;

        // Fill bank 0 in free-run mode
        start(MODE_FREERUN);
        stream(0, 64);
        check("fill_ready",     32'(bus.O_bankReady), 1);
        check("fill_readybank", 32'(bus.O_readyBank), 0);
        check("fill_inuse",     32'(bus.O_bankInUse), 1);
        check("fill_bank0",     32'(dut.bank_st[0]),  32'(FULL));
        check("fill_bank1",     32'(dut.bank_st[1]),  32'(FILLING));
        host_read(0, 2, 5);
        check("fill_rd_valid",  32'(bus.BF_O_dataValid), 1);
        check("fill_rd_025",    32'(bus.BF_O_data),      22);
        tick();
        check("fill_rd_idle",   32'(bus.BF_O_dataValid), 0);
        check("fill_rd_hold",   32'(bus.BF_O_data),      22);
        host_read(0, 3, 15);
        check("fill_rd_0315",   32'(bus.BF_O_data),      63);
        check("fill_collision", 32'(bus.O_collision),    0);

        // Lossless stall then release
        do_reset();
        start(MODE_LOSSLESS);
        stream(0, 192);
        check("stall_bank0",     32'(dut.bank_st[0]),  32'(FULL));
        check("stall_bank1",     32'(dut.bank_st[1]),  32'(FULL));
        check("stall_state",     32'(dut.state),       32'(STALL));
        check("stall_drop",      32'(bus.O_dropCount), 64);
        check("stall_overrun",   32'(bus.O_overrun),   1);
        check("stall_readybank", 32'(bus.O_readyBank), 0);
        bus.BF_I_release = 1'b1;
        tick();
        bus.BF_I_release = 1'b0;
        check("rel_bank0",     32'(dut.bank_st[0]),  32'(EMPTY));
        check("rel_bank1",     32'(dut.bank_st[1]),  32'(FULL));
        check("rel_state",     32'(dut.state),       32'(WAIT_SOF));
        check("rel_inuse",     32'(bus.O_bankInUse), 0);
        check("rel_readybank", 32'(bus.O_readyBank), 1);
        sample(500, 1'b0);
        check("rel_nosof_drop", 32'(bus.O_dropCount), 64);
        check("rel_nosof_st",   32'(dut.state),       32'(WAIT_SOF));
        sample(777, 1'b1);
        check("resume_state", 32'(dut.state),      32'(FILL));
        check("resume_bank0", 32'(dut.bank_st[0]), 32'(FILLING));
        host_read(0, 0, 0);
        check("resume_rd",    32'(bus.BF_O_data),   777);
        check("resume_coll",  32'(bus.O_collision), 1);

        // Free-run overwrite of an unreleased bank
        do_reset();
        start(MODE_FREERUN);
        stream(0, 128);
        check("ovw_overrun",   32'(bus.O_overrun),   1);
        check("ovw_ready",     32'(bus.O_bankReady), 1);
        check("ovw_readybank", 32'(bus.O_readyBank), 1);
        check("ovw_bank0",     32'(dut.bank_st[0]),  32'(FILLING));
        check("ovw_inuse",     32'(bus.O_bankInUse), 0);
        check("ovw_drop",      32'(bus.O_dropCount), 0);

        // Misplaced sof realigns to channel 0
        do_reset();
        start(MODE_FREERUN);
        sample(100, 1'b1);
        sample(101, 1'b0);
        check("sync_clean", 32'(bus.O_syncErr), 0);
        sample(102, 1'b1);
        check("sync_err",   32'(bus.O_syncErr), 1);
        sample(103, 1'b0);
        host_read(0, 0, 0);
        check("sync_rd_000", 32'(bus.BF_O_data), 102);
        host_read(0, 1, 0);
        check("sync_rd_010", 32'(bus.BF_O_data), 103);

        // Release coincident with the last write of bank 1 in lossless mode
        do_reset();
        start(MODE_LOSSLESS);
        stream(0, 127);
        check("sim_pre_bank0", 32'(dut.bank_st[0]), 32'(FULL));
        bus.BF_I_release = 1'b1;
        sample(127, 1'b0);
        check("sim_state",     32'(dut.state),       32'(FILL));
        check("sim_inuse",     32'(bus.O_bankInUse), 0);
        check("sim_bank0",     32'(dut.bank_st[0]),  32'(FILLING));
        check("sim_bank1",     32'(dut.bank_st[1]),  32'(FULL));
        check("sim_readybank", 32'(bus.O_readyBank), 1);
        sample(128, 1'b1);
        check("sim_drop",      32'(bus.O_dropCount), 0);
        check("sim_overrun",   32'(bus.O_overrun),   0);

        // Collision during fill, then reset mid-fill
        do_reset();
        start(MODE_FREERUN);
        stream(1000, 10);
        host_read(0, 0, 0);
        check("coll_rd",   32'(bus.BF_O_data),   1000);
        check("coll_flag", 32'(bus.O_collision), 1);
        rst = 1'b1;
        tick();
        check("mrst_collision", 32'(bus.O_collision),    0);
        check("mrst_rddata",    32'(bus.BF_O_data),      0);
        check("mrst_rdvalid",   32'(bus.BF_O_dataValid), 0);
        check("mrst_ready",     32'(bus.O_bankReady),    0);
        check("mrst_inuse",     32'(bus.O_bankInUse),    0);
        check("mrst_bank0",     32'(dut.bank_st[0]),     32'(EMPTY));
        check("mrst_bank1",     32'(dut.bank_st[1]),     32'(EMPTY));
        check("mrst_state",     32'(dut.state),          32'(IDLE));
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
